block_residual_loader: RTL and testbench

- Upstream feeder for the Golomb-Rice serial encoder.
- Fetches D blocks of N 8-bit pixels from a synchronous pixel memory.
- For each block, picks the prediction mode with the smaller unary-code cost and forms sign-magnitude residuals.
- Presents each block as the encoder's packed data_in/mode_in with a start/start_ack handshake. Exactly one block is in flight.

---
 rtl/block_residual_loader_pkg.sv | 31 +++
 rtl/block_residual_loader_if.sv | 29 ++
 rtl/block_residual_loader_sm_diff.sv | 19 +
 rtl/block_residual_loader.sv | 160 ++++++++++++++++
 tb/tb_block_residual_loader.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/block_residual_loader_pkg.sv
// Shared constants, FSM state type and data_out packing helper for the residual loader.
package block_residual_loader_pkg;

  localparam int unsigned W     = 8;
  localparam int unsigned LOGW  = 3;
  localparam int unsigned N     = 16;
  localparam int unsigned LOGN  = 4;
  localparam int unsigned R     = 2;
  localparam int unsigned D     = 8;
  localparam int unsigned LOGD  = 3;

  localparam int unsigned EW    = W + 1;
  localparam int unsigned DataW = N * EW;
  localparam int unsigned AddrW = LOGD + LOGN;
  localparam int unsigned CostW = 10;
  localparam int unsigned FW    = LOGN + 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecide,
    StPresent,
    StDone
  } state_e;

  // Element 0 occupies the most significant slice of data_out.
  function automatic int unsigned elem_lsb(input int unsigned idx);
    return (N - 1 - idx) * EW;
  endfunction

endpackage

// File: rtl/block_residual_loader_if.sv
// Pixel-memory port and encoder block handshake of the residual loader.
interface block_residual_loader_if;
  import block_residual_loader_pkg::*;

  logic [AddrW-1:0] mem_addr;
  logic [W-1:0]     mem_rdata;
  logic             start;
  logic             start_ack;
  logic             mode_out;
  logic [DataW-1:0] data_out;

  modport master (
    output mem_addr,
    output start,
    output mode_out,
    output data_out,
    input  mem_rdata,
    input  start_ack
  );

  modport slave (
    input  mem_addr,
    input  start,
    input  mode_out,
    input  data_out,
    output mem_rdata,
    output start_ack
  );
endinterface

// File: rtl/block_residual_loader_sm_diff.sv
// Combinational a-b as sign-magnitude {sign, mag} plus the Rice unary cost mag >> R.
module block_residual_loader_sm_diff
  import block_residual_loader_pkg::*;
(
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  output logic [EW-1:0] o_elem,
  output logic [W-1:0]  o_cost
);

  logic         w_neg;
  logic [W-1:0] w_mag;

  assign w_neg  = i_a < i_b;
  assign w_mag  = w_neg ? (i_b - i_a) : (i_a - i_b);
  assign o_elem = {w_neg, w_mag};
  assign o_cost = w_mag >> R;

endmodule

// File: rtl/block_residual_loader.sv
// Fetches D blocks of N pixels, picks the cheaper prediction mode per block and hands
// sign-magnitude residuals to the Rice encoder one block at a time.
module block_residual_loader
  import block_residual_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  block_residual_loader_if.master bus,
  output logic                    data_all_done
);

  localparam logic [LOGN-1:0] IdxOne = LOGN'(1);

  state_e           r_state;
  logic [LOGD-1:0]  r_block;
  logic [FW-1:0]    r_f;
  logic [W-1:0]     r_pix [N];
  logic [CostW-1:0] r_cost0;
  logic [CostW-1:0] r_cost1;
  logic             r_start;
  logic             r_mode;
  logic             r_done;
  logic [DataW-1:0] r_data;
  logic [AddrW-1:0] r_addr;

  logic [LOGN-1:0]  w_cap_idx;
  logic [LOGN-1:0]  w_prev_idx;
  logic [LOGD-1:0]  w_next_block;
  logic [W-1:0]     w_cost0;
  logic [W-1:0]     w_cost1;
  logic [EW-1:0]    w_unused_fetch_elem0;
  logic [EW-1:0]    w_unused_fetch_elem1;
  logic             w_mode;
  logic [EW-1:0]    w_elem [N];
  logic [W-1:0]     w_unused_dec_cost [1:N-1];
  logic [DataW-1:0] w_packed;

  // In FETCH cycle f the pixel arriving on mem_rdata is p[f-1].
  assign w_cap_idx    = r_f[LOGN-1:0] - IdxOne;
  assign w_prev_idx   = w_cap_idx - IdxOne;
  assign w_next_block = r_block + LOGD'(1);

  block_residual_loader_sm_diff u_fetch_mode0 (
    .i_a    (bus.mem_rdata),
    .i_b    (r_pix[w_prev_idx]),
    .o_elem (w_unused_fetch_elem0),
    .o_cost (w_cost0)
  );

  block_residual_loader_sm_diff u_fetch_mode1 (
    .i_a    (bus.mem_rdata),
    .i_b    (r_pix[0]),
    .o_elem (w_unused_fetch_elem1),
    .o_cost (w_cost1)
  );

  // Tie goes to mode 0.
  assign w_mode    = r_cost1 < r_cost0;
  assign w_elem[0] = {1'b0, r_pix[0]};

  for (genvar gi = 1; gi < N; gi++) begin : g_dec
    block_residual_loader_sm_diff u_dec (
      .i_a    (r_pix[gi]),
      .i_b    (w_mode ? r_pix[0] : r_pix[gi-1]),
      .o_elem (w_elem[gi]),
      .o_cost (w_unused_dec_cost[gi])
    );
  end

  always_comb begin
    w_packed = '0;
    for (int i = 0; i < N; i++) begin
      w_packed[elem_lsb(i) +: EW] = w_elem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_block <= '0;
      r_f     <= '0;
      r_cost0 <= '0;
      r_cost1 <= '0;
      r_start <= 1'b0;
      r_mode  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
      for (int i = 0; i < N; i++) begin
        r_pix[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (en) begin
            r_state <= StFetch;
            r_f     <= '0;
            r_addr  <= {r_block, {LOGN{1'b0}}};
            r_cost0 <= '0;
            r_cost1 <= '0;
          end
        end
        StFetch: begin
          // Address is left on the last pixel once all N have been issued.
          if (r_f < FW'(N - 1)) begin
            r_addr <= r_addr + AddrW'(1);
          end
          if (r_f != '0) begin
            r_pix[w_cap_idx] <= bus.mem_rdata;
          end
          if (r_f >= FW'(2)) begin
            r_cost0 <= r_cost0 + CostW'(w_cost0);
            r_cost1 <= r_cost1 + CostW'(w_cost1);
          end
          if (r_f == FW'(N)) begin
            r_state <= StDecide;
          end else begin
            r_f <= r_f + FW'(1);
          end
        end
        StDecide: begin
          r_data  <= w_packed;
          r_mode  <= w_mode;
          r_start <= 1'b1;
          r_state <= StPresent;
        end
        StPresent: begin
          if (bus.start_ack) begin
            r_start <= 1'b0;
            r_block <= w_next_block;
            if (r_block == LOGD'(D - 1)) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StFetch;
              r_f     <= '0;
              r_addr  <= {w_next_block, {LOGN{1'b0}}};
              r_cost0 <= '0;
              r_cost1 <= '0;
            end
          end
        end
        StDone: begin
          r_state <= StDone;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.mem_addr   = r_addr;
  assign bus.start      = r_start;
  assign bus.mode_out   = r_mode;
  assign bus.data_out   = r_data;
  assign data_all_done  = r_done;

endmodule

// File: tb/tb_block_residual_loader.sv
// Randomised self-checking bench: pixel memory model plus a per-block reference model.
module tb_block_residual_loader;
  import block_residual_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic data_all_done;

  block_residual_loader_if bus ();

  block_residual_loader dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .bus           (bus),
    .data_all_done (data_all_done)
  );

  always #5 clk = ~clk;

  logic [W-1:0] img [D*N];

  // Synchronous memory: data for an address appears the cycle after it is driven.
  always @(posedge clk) bus.mem_rdata <= img[bus.mem_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DataW:0] got, input logic [DataW:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Returns {mode, data_out} for block b of the current image.
  function automatic logic [DataW:0] model(input int b);
    int p [N];
    int c0;
    int c1;
    int diff;
    logic m;
    logic [DataW-1:0] d;
    c0 = 0;
    c1 = 0;
    d  = '0;
    for (int i = 0; i < N; i++) p[i] = int'(img[b*N + i]);
    for (int i = 1; i < N; i++) begin
      c0 += iabs(p[i] - p[i-1]) / (1 << R);
      c1 += iabs(p[i] - p[0]) / (1 << R);
    end
    m = (c1 < c0);
    d[(N-1)*EW +: EW] = EW'(p[0]);
    for (int i = 1; i < N; i++) begin
      diff = p[i] - (m ? p[0] : p[i-1]);
      d[(N-1-i)*EW +: EW] = (diff < 0) ? {1'b1, W'(-diff)} : {1'b0, W'(diff)};
    end
    return {m, d};
  endfunction

  function automatic logic [EW-1:0] elem_of(input logic [DataW-1:0] v, input int i);
    return v[(N-1-i)*EW +: EW];
  endfunction

  task automatic wait_start(output int cyc);
    cyc = 0;
    while (!bus.start && cyc < 200) begin
      tick();
      cyc++;
    end
    check("start_seen", DataW'(bus.start), 1);
  endtask

  task automatic present_check(input int b);
    int cyc;
    logic [DataW:0] exp;
    wait_start(cyc);
    exp = model(b);
    check($sformatf("mode_b%0d", b), DataW'(bus.mode_out), DataW'(exp[DataW]));
    check($sformatf("data_b%0d", b), DataW'(bus.data_out), DataW'(exp[DataW-1:0]));
  endtask

  task automatic ack_block(input int b, input int hold);
    int stable;
    logic [DataW:0] exp;
    exp = model(b);
    stable = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.start && bus.data_out == exp[DataW-1:0] && bus.mode_out == exp[DataW]) stable++;
    end
    if (hold > 0) check($sformatf("hold_b%0d", b), stable, hold);
    bus.start_ack = 1'b1;
    tick();
    bus.start_ack = 1'b0;
    check($sformatf("start_drop_b%0d", b), DataW'(bus.start), 0);
    check($sformatf("data_keep_b%0d", b), DataW'(bus.data_out), DataW'(exp[DataW-1:0]));
    if (b < D - 1) check($sformatf("next_addr_b%0d", b), DataW'(bus.mem_addr), (b + 1) * N);
    else check("all_done", DataW'(data_all_done), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, DataW'(bus.start), 0);
    check({tag, "_mode"}, DataW'(bus.mode_out), 0);
    check({tag, "_data"}, DataW'(bus.data_out), 0);
    check({tag, "_addr"}, DataW'(bus.mem_addr), 0);
    check({tag, "_done"}, DataW'(data_all_done), 0);
  endtask

  initial begin
    int cyc;
    int seen;
    rst = 1'b1;
    en = 1'b0;
    bus.start_ack = 1'b0;

    for (int i = 0; i < N; i++) begin
      img[0*N + i] = 8'd100;
      img[1*N + i] = W'(10 + 4 * i);
      img[2*N + i] = (i % 2 == 0) ? 8'd50 : 8'd60;
      img[3*N + i] = (i == 0) ? 8'd200 : 8'd0;
    end
    for (int i = 4 * N; i < D * N; i++) img[i] = W'($urandom_range(0, 255));

    repeat (3) tick();
    check_reset_outputs("rst0");
    rst = 1'b0;
    tick();
    check("idle_no_start", DataW'(bus.start), 0);

    en = 1'b1;
    wait_start(cyc);
    // One edge to leave IDLE, then 18 from FETCH entry.
    check("latency", cyc, 19);
    present_check(0);
    check("flat_elem0", DataW'(elem_of(bus.data_out, 0)), 9'h064);
    ack_block(0, 50);

    for (int b = 1; b < D; b++) begin
      present_check(b);
      if (b == 1) check("ramp_elem5", DataW'(elem_of(bus.data_out, 5)), 9'h004);
      if (b == 2) begin
        check("alt_mode", DataW'(bus.mode_out), 1);
        check("alt_elem2", DataW'(elem_of(bus.data_out, 2)), 9'h000);
      end
      if (b == 3) check("neg_elem1", DataW'(elem_of(bus.data_out, 1)), 9'h1C8);
      ack_block(b, int'($urandom_range(0, 5)));
    end

    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.start) seen++;
    end
    check("done_no_start", seen, 0);
    check("done_sticky", DataW'(data_all_done), 1);
    check("done_addr_held", DataW'(bus.mem_addr), D * N - 1);

    // Second run, aborted by reset during FETCH of block 3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < D * N; i++) img[i] = W'($urandom_range(0, 255));
    for (int b = 0; b < 3; b++) begin
      present_check(b);
      ack_block(b, int'($urandom_range(0, 3)));
    end
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_mid");
    for (int i = 0; i < D * N; i++) img[i] = W'($urandom_range(0, 255));
    rst = 1'b0;
    tick();
    check("rerun_addr0", DataW'(bus.mem_addr), 0);
    tick();
    check("rerun_addr1", DataW'(bus.mem_addr), 1);
    for (int b = 0; b < 2; b++) begin
      present_check(b);
      ack_block(b, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
